// File: rtl/spi_mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_mem_port_arbiter_if
// Brief    : SPI write port, core burst-read port and memory port bundle.
// Revision : 1.0
// ============================================================================
interface spi_mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              spi_wr_req;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [DATA_W-1:0] spi_wr_data;
  logic              spi_wr_ack;

  logic              core_rd_req;
  logic [ADDR_W-1:0] core_rd_base;
  logic [LEN_W-1:0]  core_rd_len;
  logic              core_rd_busy;
  logic              core_rd_valid;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_rd_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  spi_wr_req, spi_wr_addr, spi_wr_data,
    output spi_wr_ack,
    input  core_rd_req, core_rd_base, core_rd_len,
    output core_rd_busy, core_rd_valid, core_rd_data, core_rd_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory view
  modport master (
    output spi_wr_req, spi_wr_addr, spi_wr_data,
    input  spi_wr_ack,
    output core_rd_req, core_rd_base, core_rd_len,
    input  core_rd_busy, core_rd_valid, core_rd_data, core_rd_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/spi_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_mem_port_arbiter
// Brief    : Round-robin arbiter sharing a single-port memory between one-beat
//            SPI writes and non-preemptible core read bursts.
// Revision : 1.0
// ============================================================================
module spi_mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input wire clk,
  input wire reset,
  spi_mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SPI_WR     = 2'd1,
    CORE_RD    = 2'd2,
    CORE_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_last_core, w_last_core_next;
  logic [LEN_W-1:0]  r_remaining, w_remaining_next;
  logic              r_mem_en, w_mem_en_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic              r_spi_ack, w_spi_ack_next;
  logic              r_busy, w_busy_next;
  logic              r_valid, w_valid_next;
  logic              r_done, w_done_next;

  logic              w_grant_spi;
  logic              w_grant_core;

  // On a tie the side that was not granted last wins.
  assign w_grant_spi  = bus.spi_wr_req & (~bus.core_rd_req | r_last_core);
  assign w_grant_core = bus.core_rd_req & ~w_grant_spi;

  always_comb begin
    w_state_next     = r_state;
    w_last_core_next = r_last_core;
    w_remaining_next = r_remaining;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_spi_ack_next   = 1'b0;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    // Read data returns one cycle after the read cycle.
    w_valid_next     = r_mem_en & ~r_mem_we;

    case (r_state)
      IDLE: begin
        if (w_grant_spi) begin
          w_state_next     = SPI_WR;
          w_last_core_next = 1'b0;
          w_mem_en_next    = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = bus.spi_wr_addr;
          w_mem_wdata_next = bus.spi_wr_data;
          w_spi_ack_next   = 1'b1;
        end else if (w_grant_core) begin
          w_state_next     = CORE_RD;
          w_last_core_next = 1'b1;
          w_remaining_next = bus.core_rd_len;
          w_mem_en_next    = (bus.core_rd_len != '0);
          w_mem_addr_next  = bus.core_rd_base;
          w_busy_next      = 1'b1;
          w_done_next      = (bus.core_rd_len == '0);
        end
      end

      SPI_WR: begin
        w_state_next = IDLE;
      end

      CORE_RD: begin
        // A zero-length burst spends its single done cycle here.
        if (r_remaining == '0) begin
          w_state_next = IDLE;
        end else if (r_remaining == LEN_W'(1)) begin
          w_state_next = CORE_DRAIN;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b1;
        end else begin
          w_remaining_next = r_remaining - LEN_W'(1);
          w_mem_addr_next  = r_mem_addr + ADDR_W'(1);
          w_mem_en_next    = 1'b1;
          w_busy_next      = 1'b1;
        end
      end

      CORE_DRAIN: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_core <= 1'b1;
      r_remaining <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_spi_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_last_core <= w_last_core_next;
      r_remaining <= w_remaining_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_spi_ack   <= w_spi_ack_next;
      r_busy      <= w_busy_next;
      r_valid     <= w_valid_next;
      r_done      <= w_done_next;
    end
  end

  assign bus.mem_en        = r_mem_en;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.spi_wr_ack    = r_spi_ack;
  assign bus.core_rd_busy  = r_busy;
  assign bus.core_rd_valid = r_valid;
  assign bus.core_rd_done  = r_done;
  assign bus.core_rd_data  = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_port_arbiter
// Brief    : Directed self-checking bench for spi_mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_spi_mem_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   ack_at;
  logic we_in_burst;
  logic late_activity;
  logic [15:0] exp_a;

  spi_mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) bus ();

  spi_mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the low address byte one cycle after a read.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control bits in order {mem_en, mem_we, spi_wr_ack, busy, valid, done}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({bus.mem_en, bus.mem_we, bus.spi_wr_ack,
                  bus.core_rd_busy, bus.core_rd_valid, bus.core_rd_done}), 32'(exp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.spi_wr_req   = 1'b0;
    bus.spi_wr_addr  = '0;
    bus.spi_wr_data  = '0;
    bus.core_rd_req  = 1'b0;
    bus.core_rd_base = '0;
    bus.core_rd_len  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_ctl("rst_ctl", 6'b000000);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    reset = 1'b0;
    tick();

    // SPI-only write
    bus.spi_wr_req = 1'b1; bus.spi_wr_addr = 16'h0123; bus.spi_wr_data = 8'hA5;
    tick();
    chk_ctl("spi_wr_ctl", 6'b111000);
    chk("spi_wr_addr", 32'(bus.mem_addr), 32'h0123);
    chk("spi_wr_data", 32'(bus.mem_wdata), 32'hA5);
    bus.spi_wr_req = 1'b0;
    tick();
    chk_ctl("spi_after", 6'b000000);

    // Burst base 0x0010 len 4; inputs scrambled after grant must not matter
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'h0010; bus.core_rd_len = 8'd4;
    tick();
    bus.core_rd_req = 1'b0; bus.core_rd_base = 16'hFFFF; bus.core_rd_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("burst_ctl%0d", i), (i == 0) ? 6'b100100 : 6'b100110);
      chk($sformatf("burst_addr%0d", i), 32'(bus.mem_addr), 32'(16'h0010 + i));
      if (i > 0) chk($sformatf("burst_data%0d", i), 32'(bus.core_rd_data), 32'(8'h10 + i - 1));
      tick();
    end
    chk_ctl("burst_drain", 6'b000111);
    chk("burst_data3", 32'(bus.core_rd_data), 32'h13);
    tick();
    chk_ctl("burst_end", 6'b000000);

    // Tie after reset: SPI first, then core, with SPI re-requesting meanwhile
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.spi_wr_req  = 1'b1; bus.spi_wr_addr  = 16'h0200; bus.spi_wr_data = 8'h5A;
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'h0030; bus.core_rd_len = 8'd2;
    tick();
    chk_ctl("tie1_spi", 6'b111000);
    chk("tie1_addr", 32'(bus.mem_addr), 32'h0200);
    tick();
    chk_ctl("tie_idle", 6'b000000);
    tick();
    chk_ctl("tie2_core", 6'b100100);
    chk("tie2_addr", 32'(bus.mem_addr), 32'h0030);
    bus.core_rd_req = 1'b0;
    tick();
    chk_ctl("tie2_beat1", 6'b100110);
    chk("tie2_addr1", 32'(bus.mem_addr), 32'h0031);
    chk("tie2_data0", 32'(bus.core_rd_data), 32'h30);
    tick();
    chk_ctl("tie2_drain", 6'b000111);
    chk("tie2_data1", 32'(bus.core_rd_data), 32'h31);
    tick();
    chk_ctl("tie2_idle", 6'b000000);
    tick();
    chk_ctl("tie3_spi", 6'b111000);
    chk("tie3_addr", 32'(bus.mem_addr), 32'h0200);
    bus.spi_wr_req = 1'b0;
    tick();

    // SPI request mid-burst (len 8) waits len+2 cycles
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'h0100; bus.core_rd_len = 8'd8;
    tick();
    bus.core_rd_req = 1'b0;
    bus.spi_wr_req = 1'b1; bus.spi_wr_addr = 16'h0777; bus.spi_wr_data = 8'h3C;
    ack_at = -1;
    we_in_burst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.core_rd_busy && bus.mem_we) we_in_burst = 1'b1;
      if (bus.spi_wr_ack === 1'b1 && ack_at < 0) begin
        ack_at = k;
        chk("mid_addr", 32'(bus.mem_addr), 32'h0777);
        bus.spi_wr_req = 1'b0;
      end
    end
    chk("mid_wait", 32'(ack_at), 32'd10);
    chk("mid_no_write", 32'(we_in_burst), 32'd0);

    // Address wrap
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'hFFFE; bus.core_rd_len = 8'd3;
    tick();
    bus.core_rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_a = 16'(16'hFFFE + i);
      chk($sformatf("wrap_addr%0d", i), 32'(bus.mem_addr), 32'(exp_a));
      if (i > 0) chk($sformatf("wrap_data%0d", i), 32'(bus.core_rd_data), 32'(8'(exp_a - 16'd1)));
      tick();
    end
    chk_ctl("wrap_drain", 6'b000111);
    chk("wrap_data2", 32'(bus.core_rd_data), 32'h00);
    tick();

    // Zero-length burst
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'h4444; bus.core_rd_len = 8'd0;
    tick();
    bus.core_rd_req = 1'b0;
    chk_ctl("len0_done", 6'b000101);
    tick();
    chk_ctl("len0_after", 6'b000000);

    // Reset during beat 2 of a len 5 burst
    bus.core_rd_req = 1'b1; bus.core_rd_base = 16'h0050; bus.core_rd_len = 8'd5;
    tick();
    bus.core_rd_req = 1'b0;
    chk("rstm_addr0", 32'(bus.mem_addr), 32'h0050);
    tick();
    chk("rstm_addr1", 32'(bus.mem_addr), 32'h0051);
    reset = 1'b1;
    #1;
    chk_ctl("rstm_ctl", 6'b000000);
    chk("rstm_maddr", 32'(bus.mem_addr), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    late_activity = 1'b0;
    repeat (4) begin
      tick();
      if (bus.core_rd_done || bus.core_rd_valid || bus.mem_en) late_activity = 1'b1;
    end
    chk("rstm_quiet", 32'(late_activity), 32'd0);
    bus.spi_wr_req = 1'b1; bus.spi_wr_addr = 16'h0ABC; bus.spi_wr_data = 8'h77;
    tick();
    chk_ctl("rstm_spi", 6'b111000);
    chk("rstm_spi_addr", 32'(bus.mem_addr), 32'h0ABC);
    chk("rstm_spi_data", 32'(bus.mem_wdata), 32'h77);
    bus.spi_wr_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
